sipo_rx: RTL and testbench

Framed serial-to-parallel receiver. It samples a strobed serial line and assembles WIDTH-bit words. Each word is framed by a start bit and a stop bit. Completed words are presented on a valid/ready parallel output. It is the receiving end of the serial stream produced by the universal shift register running in load-then-shift mode, and it sits between that serial link and the consuming parallel logic.

---
 rtl/sipo_rx_pkg.sv | 18 +
 rtl/sipo_rx_hold.sv | 60 ++++++
 rtl/sipo_rx.sv | 100 ++++++++++
 tb/tb_sipo_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the framed serial receiver: FSM encodings and the
// default word width used by both ends of the serial link.
package sipo_rx_pkg;

    localparam int DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        STOP = 2'd2
    } state_e;

    // Bit counter must be able to hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_rx_hold.sv
// Parallel output holding register with valid/ready handshake and sticky
// overrun flag; loads a completed word on the word_done pulse from the FSM.
module sipo_rx_hold
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             word_done,
    input  logic [WIDTH-1:0] word_data,
    input  logic             po_ready,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] po_q, po_d;
    logic             po_valid_q, po_valid_d;
    logic             overrun_q, overrun_d;

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        po_d       = po_q;
        po_valid_d = po_valid_q;
        overrun_d  = overrun_q;

        // A handshake on the same edge frees the register for the new word.
        if (word_done && (!po_valid_q || po_ready)) begin
            po_d       = word_data;
            po_valid_d = 1'b1;
        end else if (po_valid_q && po_ready) begin
            po_valid_d = 1'b0;
        end

        if (word_done && po_valid_q && !po_ready) begin
            overrun_d = 1'b1;
        end
    end

    // NOTE: flops use non-blocking assignments so all registers update
    // together from pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            po_q       <= '0;
            po_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            po_q       <= po_d;
            po_valid_q <= po_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign po       = po_q;
    assign po_valid = po_valid_q;
    assign overrun  = overrun_q;

endmodule

// File: rtl/sipo_rx.sv
// Framed serial-to-parallel receiver: start bit (1), WIDTH data bits, stop
// bit (0), all sampled on si_valid strobes; words leave via valid/ready.
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             si_valid,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic             word_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (si_valid) begin
            case (state_q)
                IDLE:    if (si) state_d = RECV;
                RECV:    if (cnt_q == LAST_BIT) state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        word_done   = 1'b0;
        frame_err_d = 1'b0;
        // Registered so busy has no combinational path from si.
        busy_d      = (state_d != IDLE);

        if (si_valid) begin
            case (state_q)
                IDLE: begin
                    if (si) cnt_d = '0;
                end
                RECV: begin
                    if (MSB_FIRST) sr_d = {sr_q[WIDTH-2:0], si};
                    else           sr_d = {si, sr_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                end
                STOP: begin
                    word_done   = ~si;
                    frame_err_d = si;
                end
                default: ;
            endcase
        end
    end

    sipo_rx_hold #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .word_done (word_done),
        .word_data (sr_q),
        .po_ready  (po_ready),
        .po        (po),
        .po_valid  (po_valid),
        .overrun   (overrun)
    );

    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: an MSB-first and an LSB-first instance share
// one serial stream; expected words are queued on send, compared on transfer.
module tb_sipo_rx;
    import sipo_rx_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst, si, si_valid, po_ready;
    logic [W-1:0] po_m, po_l;
    logic         pv_m, pv_l, busy_m, busy_l, fe_m, fe_l, ov_m, ov_l;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .si(si), .si_valid(si_valid),
        .po(po_m), .po_valid(pv_m), .po_ready(po_ready),
        .busy(busy_m), .frame_err(fe_m), .overrun(ov_m)
    );

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .si(si), .si_valid(si_valid),
        .po(po_l), .po_valid(pv_l), .po_ready(po_ready),
        .busy(busy_l), .frame_err(fe_l), .overrun(ov_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = w[W-1-i];
        return r;
    endfunction

    // A transfer happens on the next rising edge whenever both are high here.
    always @(negedge clk) begin : monitor
        logic [W-1:0] w;
        if (!rst && pv_m && po_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                w = sb.pop_front();
                check("xfer_po_msb", 32'(po_m), 32'(w));
                check("xfer_po_lsb", 32'(po_l), 32'(rev(w)));
                check("xfer_valid_lsb", 32'(pv_l), 32'd1);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_po_msb"}, 32'(po_m), 32'd0);
        check({tag, "_po_lsb"}, 32'(po_l), 32'd0);
        check({tag, "_valid"}, 32'({pv_m, pv_l}), 32'd0);
        check({tag, "_busy"}, 32'({busy_m, busy_l}), 32'd0);
        check({tag, "_frame_err"}, 32'({fe_m, fe_l}), 32'd0);
        check({tag, "_overrun"}, 32'({ov_m, ov_l}), 32'd0);
    endtask

    task automatic check_held(input string tag, input logic [W-1:0] w);
        check({tag, "_valid"}, 32'({pv_m, pv_l}), 32'b11);
        check({tag, "_po_msb"}, 32'(po_m), 32'(w));
        check({tag, "_po_lsb"}, 32'(po_l), 32'(rev(w)));
    endtask

    // Random idle gap (si toggling, strobe low) then one strobed bit.
    task automatic strobe(input logic b, input int max_gap);
        int n;
        n = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (n) begin
            @(posedge clk); #2;
            si_valid = 1'b0;
            si       = 1'($urandom);
        end
        @(posedge clk); #2;
        si_valid = 1'b1;
        si       = b;
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic stop, input int gap,
                              input bit ready_at_stop, input bit settle);
        strobe(1'b1, gap);
        for (int i = W - 1; i >= 0; i--) begin
            strobe(word[i], gap);
            if (i == W - 1) check("busy_in_frame", 32'({busy_m, busy_l}), 32'b11);
        end
        strobe(stop, gap);
        if (ready_at_stop) po_ready = 1'b1;
        if (settle) begin
            @(posedge clk); #1;
            check("frame_err_msb", 32'(fe_m), 32'(stop));
            check("frame_err_lsb", 32'(fe_l), 32'(stop));
            check("busy_after_stop", 32'({busy_m, busy_l}), 32'd0);
            #1 si_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        po_ready = 1'b1;
        while (pv_m && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_drained"}, 32'({pv_m, pv_l}), 32'd0);
        po_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst      = 1'b1;
        si_valid = 1'b0;
        po_ready = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        si       = 1'b0;
        si_valid = 1'b0;
        po_ready = 1'b0;
        do_reset();

        // Basic frame in both assembly orders, then a single handshake.
        sb.push_back(5'b10110);
        send_frame(5'b10110, 1'b0, 0, 1'b0, 1'b1);
        check_held("t1", 5'b10110);
        check("t1_lsb_word", 32'(po_l), 32'(5'b01101));
        po_ready = 1'b1;
        @(posedge clk); #1;
        check("t1_valid_cleared", 32'({pv_m, pv_l}), 32'd0);
        po_ready = 1'b0;

        // Back-to-back frames with no consumer: second word overruns.
        sb.push_back(5'b10110);
        send_frame(5'b10110, 1'b0, 0, 1'b0, 1'b0);
        send_frame(5'b00011, 1'b0, 0, 1'b0, 1'b1);
        check_held("t3", 5'b10110);
        check("t3_overrun", 32'({ov_m, ov_l}), 32'b11);
        drain("t3");
        check("t3_overrun_sticky", 32'({ov_m, ov_l}), 32'b11);
        do_reset();

        // A line idling at 0 never starts a frame.
        repeat (4) strobe(1'b0, 1);
        @(posedge clk); #1;
        check("idle0_busy", 32'({busy_m, busy_l}), 32'd0);
        check("idle0_valid", 32'({pv_m, pv_l}), 32'd0);
        #1 si_valid = 1'b0;

        // Bad stop bit: one-cycle frame_err, nothing delivered, then recovery.
        send_frame(5'b11111, 1'b1, 2, 1'b0, 1'b1);
        check("t4_no_valid", 32'({pv_m, pv_l}), 32'd0);
        @(posedge clk); #1;
        check("t4_frame_err_pulse", 32'({fe_m, fe_l}), 32'd0);
        sb.push_back(5'b00101);
        send_frame(5'b00101, 1'b0, 2, 1'b0, 1'b1);
        check_held("t4_good", 5'b00101);
        drain("t4");

        // Handshake of word A lands on word B's stop edge: no gap, no overrun.
        sb.push_back(5'b01001);
        send_frame(5'b01001, 1'b0, 1, 1'b0, 1'b1);
        check_held("t5_a", 5'b01001);
        sb.push_back(5'b11010);
        send_frame(5'b11010, 1'b0, 1, 1'b1, 1'b1);
        check_held("t5_b", 5'b11010);
        check("t5_no_overrun", 32'({ov_m, ov_l}), 32'd0);
        @(posedge clk); #1;
        check("t5_valid_cleared", 32'({pv_m, pv_l}), 32'd0);
        po_ready = 1'b0;

        // Reset after the third data bit aborts the frame silently.
        sb.push_back(5'b11010);
        send_frame(5'b11010, 1'b0, 2, 1'b0, 1'b1);
        strobe(1'b1, 2);
        strobe(1'b0, 2);
        strobe(1'b1, 2);
        strobe(1'b1, 2);
        @(posedge clk); #1;
        check("t6_busy_before_rst", 32'({busy_m, busy_l}), 32'b11);
        rst      = 1'b1;
        si_valid = 1'b0;
        #1 check_all_zero("t6_in_reset");
        void'(sb.pop_front());
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        sb.push_back(5'b01010);
        send_frame(5'b01010, 1'b0, 3, 1'b0, 1'b1);
        check_held("t6", 5'b01010);
        check("t6_no_overrun", 32'({ov_m, ov_l}), 32'd0);
        drain("t6");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
